// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized line, mid-bit sampling from a half-bit
// start qualification, single-byte holding register with overrun and framing flags.
//
// state   | meaning
// S_IDLE  | line idle, waiting for a low on rxd_s
// S_START | counting to mid start bit; line high there means a glitch
// S_DATA  | sampling 8 data bits, LSB first, one per CPB cycles
// S_STOP  | sampling the stop bit
// S_BREAK | stop bit was low; wait for the line to return high
module uart_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       uart_rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = ($clog2(CPB) > 16) ? $clog2(CPB) : 16;
    localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bidx_q, bidx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ovr_q, ovr_d;
    logic            ferr_q, ferr_d;
    logic            sync1_q, rxd_s_q;
    logic            deliver;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        ferr_d  = 1'b0;
        deliver = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxd_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bidx_d  = 3'd0;
                    state_d = rxd_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d           = '0;
                    shift_d[bidx_q] = rxd_s_q;
                    if (bidx_q == 3'd7) state_d = S_STOP;
                    else                bidx_d  = bidx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d = '0;
                    if (rxd_s_q) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rxd_s_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // An ack landing in the delivery cycle consumes the old byte, so no overrun.
        if (deliver) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && rx_ack)  ovr_d = 1'b0;
            else if (valid_q)       ovr_d = 1'b1;
        end else if (valid_q && rx_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sync1_q <= 1'b1;
            rxd_s_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bidx_q  <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= uart_rxd;
            rxd_s_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_overrun   = ovr_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_HZ=160, BAUD=10 (16 clocks per bit, half bit 8).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset_b = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       rx_busy;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int ferr_cnt = 0;
    logic valid_prev = 1'b0;

    uart_rx #(.CLK_HZ(160), .BAUD(10)) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .uart_rxd     (uart_rxd),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (rx_valid === 1'b1 && valid_prev !== 1'b1) rise_cyc <= cyc;
        valid_prev <= rx_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

    // Start bit driven just after a rising edge; each bit lasts 16 clocks.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk); #1 uart_rxd = 1'b0; start_cyc = cyc;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 uart_rxd = b[i];
            repeat (16) @(posedge clk);
        end
        #1 uart_rxd = stop;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        @(posedge clk); #1 rx_ack = 1'b1;
        @(posedge clk); #1 rx_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3 reset_b = 1'b0;
        #1;
        vecs++; if (rx_data !== 8'h00)    begin errs++; $display("FAIL reset_data: got %h want 00", rx_data); end
        vecs++; if (rx_valid !== 1'b0)    begin errs++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        vecs++; if (rx_overrun !== 1'b0)  begin errs++; $display("FAIL reset_overrun: got %b want 0", rx_overrun); end
        vecs++; if (rx_frame_err !== 1'b0) begin errs++; $display("FAIL reset_ferr: got %b want 0", rx_frame_err); end
        vecs++; if (rx_busy !== 1'b0)     begin errs++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int f0;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        @(negedge clk);
        vecs++; if (rx_data !== 8'hA5) begin errs++; $display("FAIL single_data: got %h want a5", rx_data); end
        vecs++; if (rx_valid !== 1'b1) begin errs++; $display("FAIL single_valid: got %b want 1", rx_valid); end
        vecs++; if (rise_cyc - start_cyc < 154 || rise_cyc - start_cyc > 156)
            begin errs++; $display("FAIL single_latency: got %0d want 154..156", rise_cyc - start_cyc); end
        vecs++; if (ferr_cnt !== f0) begin errs++; $display("FAIL single_ferr: got %0d pulses want 0", ferr_cnt - f0); end
        vecs++; if (rx_busy !== 1'b0) begin errs++; $display("FAIL single_busy: got %b want 0", rx_busy); end
        pulse_ack();
        vecs++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL single_ack_valid: got %b want 0", rx_valid); end
        pulse_ack();
        vecs++; if (rx_valid !== 1'b0 || rx_overrun !== 1'b0)
            begin errs++; $display("FAIL idle_ack_flags: got v=%b o=%b want v=0 o=0", rx_valid, rx_overrun); end
        vecs++; if (rx_data !== 8'hA5) begin errs++; $display("FAIL idle_ack_data: got %h want a5", rx_data); end
    endtask

    task automatic test_overrun();
        send_frame(8'h3C, 1'b1);
        @(negedge clk);
        vecs++; if (rx_data !== 8'h3C || rx_overrun !== 1'b0)
            begin errs++; $display("FAIL ovr_first: got d=%h o=%b want d=3c o=0", rx_data, rx_overrun); end
        send_frame(8'hC3, 1'b1);
        @(negedge clk);
        vecs++; if (rx_data !== 8'hC3) begin errs++; $display("FAIL ovr_data: got %h want c3", rx_data); end
        vecs++; if (rx_valid !== 1'b1) begin errs++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
        vecs++; if (rx_overrun !== 1'b1) begin errs++; $display("FAIL ovr_flag: got %b want 1", rx_overrun); end
        pulse_ack();
        vecs++; if (rx_valid !== 1'b0 || rx_overrun !== 1'b0)
            begin errs++; $display("FAIL ovr_ack: got v=%b o=%b want v=0 o=0", rx_valid, rx_overrun); end
    endtask

    task automatic test_frame_err();
        int f0;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        vecs++; if (ferr_cnt - f0 !== 1) begin errs++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt - f0); end
        vecs++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL ferr_valid: got %b want 0", rx_valid); end
        vecs++; if (rx_data !== 8'hC3) begin errs++; $display("FAIL ferr_data: got %h want c3", rx_data); end
        vecs++; if (rx_busy !== 1'b1) begin errs++; $display("FAIL ferr_break_busy: got %b want 1", rx_busy); end
        @(posedge clk); #1 uart_rxd = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        vecs++; if (rx_busy !== 1'b0) begin errs++; $display("FAIL ferr_break_exit: got %b want 0", rx_busy); end
        send_frame(8'h0F, 1'b1);
        @(negedge clk);
        vecs++; if (rx_data !== 8'h0F || rx_valid !== 1'b1)
            begin errs++; $display("FAIL ferr_next: got d=%h v=%b want d=0f v=1", rx_data, rx_valid); end
        vecs++; if (ferr_cnt - f0 !== 1) begin errs++; $display("FAIL ferr_next_pulses: got %0d want 1", ferr_cnt - f0); end
        pulse_ack();
    endtask

    task automatic test_glitch();
        int f0;
        f0 = ferr_cnt;
        @(posedge clk); #1 uart_rxd = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        vecs++; if (rx_busy !== 1'b1) begin errs++; $display("FAIL glitch_start: got busy=%b want 1", rx_busy); end
        @(posedge clk); #1 uart_rxd = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        vecs++; if (rx_busy !== 1'b0) begin errs++; $display("FAIL glitch_idle: got busy=%b want 0", rx_busy); end
        vecs++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
        vecs++; if (ferr_cnt !== f0) begin errs++; $display("FAIL glitch_ferr: got %0d pulses want 0", ferr_cnt - f0); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h12, 1'b1);
        @(negedge clk);
        vecs++; if (rx_data !== 8'h12 || rx_valid !== 1'b1)
            begin errs++; $display("FAIL b2b_first: got d=%h v=%b want d=12 v=1", rx_data, rx_valid); end
        fork
            send_frame(8'h34, 1'b1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1 rx_ack = 1'b1;
                @(posedge clk);
                #1 rx_ack = 1'b0;
            end
        join
        @(negedge clk);
        vecs++; if (rx_data !== 8'h34) begin errs++; $display("FAIL b2b_data: got %h want 34", rx_data); end
        vecs++; if (rx_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid: got %b want 1", rx_valid); end
        vecs++; if (rx_overrun !== 1'b0) begin errs++; $display("FAIL b2b_overrun: got %b want 0", rx_overrun); end
    endtask

    task automatic test_reset_midframe();
        int f0;
        f0 = ferr_cnt;
        fork
            send_frame(8'hF5, 1'b1);
            begin
                @(posedge clk);
                repeat (85) @(posedge clk);
                #1 reset_b = 1'b0;
                #2;
                vecs++; if (rx_data !== 8'h00) begin errs++; $display("FAIL mid_rst_data: got %h want 00", rx_data); end
                vecs++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_valid: got %b want 0", rx_valid); end
                vecs++; if (rx_busy !== 1'b0) begin errs++; $display("FAIL mid_rst_busy: got %b want 0", rx_busy); end
                vecs++; if (rx_overrun !== 1'b0 || rx_frame_err !== 1'b0)
                    begin errs++; $display("FAIL mid_rst_flags: got o=%b f=%b want 0 0", rx_overrun, rx_frame_err); end
                @(negedge clk);
                reset_b = 1'b1;
            end
        join
        repeat (20) @(posedge clk);
        @(negedge clk);
        vecs++; if (rx_valid !== 1'b0 || rx_data !== 8'h00)
            begin errs++; $display("FAIL mid_no_delivery: got v=%b d=%h want v=0 d=00", rx_valid, rx_data); end
        vecs++; if (ferr_cnt !== f0) begin errs++; $display("FAIL mid_ferr: got %0d pulses want 0", ferr_cnt - f0); end
        send_frame(8'h5A, 1'b1);
        @(negedge clk);
        vecs++; if (rx_data !== 8'h5A || rx_valid !== 1'b1)
            begin errs++; $display("FAIL mid_recover: got d=%h v=%b want d=5a v=1", rx_data, rx_valid); end
        vecs++; if (rise_cyc - start_cyc < 154 || rise_cyc - start_cyc > 156)
            begin errs++; $display("FAIL mid_latency: got %0d want 154..156", rise_cyc - start_cyc); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate.
REQ-003 Derived CPB = CLK_HZ/BAUD (integer truncation, 5208 at defaults) and HALF = CPB/2 (2604); CPB SHALL be >= 4.
REQ-004 clk  input  1  single clock, rising edge (the 50 MHz clock feeding the UART path).
REQ-005 reset_b  input  1  asynchronous, active-low reset.
REQ-006 uart_rxd  input  1  asynchronous serial line; idle high; 8N1 format, LSB first.
REQ-007 rx_ack  input  1  consumer acknowledge; the held byte is accepted on any cycle where rx_ack=1 and rx_valid=1.
REQ-008 rx_data  output  8  last received byte.
REQ-009 rx_valid  output  1  held byte not yet acknowledged.
REQ-010 rx_overrun  output  1  sticky: a byte was lost because rx_valid was still set.
REQ-011 rx_frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-012 rx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 uart_rxd SHALL pass through a 2-flop synchronizer; its output rxd_s resets to 1; all FSM decisions use rxd_s only.
REQ-014 FSM states: IDLE, START, DATA, STOP, BREAK; one counter cnt of at least 16 bits; one bit index bidx of 3 bits.
REQ-015 IDLE: rxd_s=0 -> START, cnt=0.
REQ-016 START: cnt increments each cycle; at cnt=HALF-1, rxd_s=0 -> DATA with cnt=0 and bidx=0; rxd_s=1 -> IDLE (glitch rejected, no output activity).
REQ-017 DATA: at cnt=CPB-1, shift rxd_s into bit bidx of the shift register (LSB first) and clear cnt; bidx=7 -> STOP, else bidx+1.
REQ-018 STOP: at cnt=CPB-1, rxd_s=1 -> deliver the byte and go to IDLE; rxd_s=0 -> pulse rx_frame_err for one cycle, discard the byte, go to BREAK.
REQ-019 BREAK: remain until rxd_s=1, then IDLE; a held-low line SHALL NOT produce repeated frames.
REQ-020 Deliver: rx_data <= shift register, rx_valid <= 1 on the cycle after the stop sample; if rx_valid=1 and rx_ack=0 in that cycle, rx_data is overwritten and rx_overrun <= 1.
REQ-021 rx_ack=1 with rx_valid=1 and no delivery: rx_valid <= 0 and rx_overrun <= 0 next cycle.
REQ-022 Delivery and ack in the same cycle: the new byte is loaded, rx_valid stays 1, rx_overrun <= 0.
REQ-023 rx_ack while rx_valid=0 SHALL have no effect.
REQ-024 rx_data SHALL remain stable while rx_valid=1 unless a delivery occurs.
REQ-025 Latency: rx_valid rises 2 + HALF + 9*CPB + 1 cycles (+/-1) after the uart_rxd falling edge of the start bit.
REQ-026 rx_busy is combinational from the state register (state != IDLE).

Reset
REQ-027 reset_b=0 SHALL immediately force: state IDLE, cnt=0, bidx=0, synchronizer flops=1, shift register=0, rx_data=8'h00, rx_valid=0, rx_overrun=0, rx_frame_err=0, rx_busy=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no delivery; after release the block waits for a fresh falling edge, and the remainder of the aborted frame may be received as garbage or as a framing error only.

Verification (CLK_HZ=160, BAUD=10 -> CPB=16, HALF=8)
REQ-029 Send 0xA5 with a valid stop bit -> rx_data=8'hA5, rx_valid=1 at ~155 cycles after the start edge, rx_frame_err never pulses; ack -> rx_valid=0 next cycle.
REQ-030 Send 0x3C then 0xC3 with no ack -> rx_data=8'hC3, rx_valid=1, rx_overrun=1; ack -> both flags 0.
REQ-031 Stop bit held low, byte 0x55 -> one rx_frame_err pulse, rx_valid unchanged, FSM in BREAK until the line goes high, then the next byte 0x0F is received correctly.
REQ-032 5-cycle low glitch on idle line -> FSM returns to IDLE from START, no rx_valid, no rx_frame_err.
REQ-033 rx_ack asserted in the exact delivery cycle of a second byte -> rx_valid stays 1 with the new byte, rx_overrun=0.
REQ-034 reset_b pulsed low during bit 4 of a frame -> all outputs return to reset values asynchronously; no delivery of that frame.
